// File: rtl/apu_pkg.sv
// Shared APU constants and types used by the parametrised timer bank.
package apu_pkg;

   localparam int unsigned APU_TIMER_CH_NUM   = 3;
   localparam int unsigned APU_TIMER_PRE_SLOW = 128;
   localparam int unsigned APU_TIMER_PRE_FAST = 16;

   typedef struct packed {
      logic [7:0] stage;
      logic [3:0] count;
   } apu_timer_state_t;

   typedef enum logic [3:0] {
      AT_TEST     = 4'h0,
      AT_CONTROL  = 4'h1,
      AT_TIMER0   = 4'hA,
      AT_TIMER1   = 4'hB,
      AT_TIMER2   = 4'hC,
      AT_COUNTER0 = 4'hD,
      AT_COUNTER1 = 4'hE,
      AT_COUNTER2 = 4'hF
   } apu_at_t;

   // Non-timer addresses map to 3, which the bank treats as out of range.
   function automatic logic [1:0] apu_timer_ch_of(apu_at_t at);
      case (at)
         AT_TIMER0, AT_COUNTER0: return 2'd0;
         AT_TIMER1, AT_COUNTER1: return 2'd1;
         AT_TIMER2, AT_COUNTER2: return 2'd2;
         default:                return 2'd3;
      endcase
   endfunction

endpackage

// File: rtl/apu_timer_bank_if.sv
// Register-side bus of the timer bank: divisor writes, counter reads, divisor readback.
interface apu_timer_bank_if #(
   parameter int unsigned CH_NUM = 3,
   parameter int unsigned DIV_W  = 8,
   parameter int unsigned CNT_W  = 4
);
   localparam int unsigned CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

   logic                    div_we;
   logic [CH_W-1:0]         wr_ch;
   logic [DIV_W-1:0]        div_wdata;
   logic                    cnt_re;
   logic [CH_W-1:0]         rd_ch;
   logic [CNT_W-1:0]        cnt_rdata;
   logic [CH_NUM*DIV_W-1:0] div_q;

   modport master (
      output div_we, wr_ch, div_wdata, cnt_re, rd_ch,
      input  cnt_rdata, div_q
   );

   modport slave (
      input  div_we, wr_ch, div_wdata, cnt_re, rd_ch,
      output cnt_rdata, div_q
   );
endinterface

// File: rtl/apu_timer_ch.sv
// One timer channel: enable-edge clear, stage divider, clear-on-read counter.
// Optional sticky overflow flag under APU_TIMER_OVF_EN.
module apu_timer_ch
   import apu_pkg::*;
#(
   parameter int unsigned DIV_W = 8,
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cen,
   input  logic             enable,
   input  logic             tick,
   input  logic             clr,
   input  logic [DIV_W-1:0] div,
   output logic [CNT_W-1:0] count
`ifdef APU_TIMER_OVF_EN
   ,
   output logic             ovf
`endif
);

   logic             enable_q;
   logic [DIV_W-1:0] stage_q, stage_d, stage_inc;
   logic [CNT_W-1:0] count_q, count_d;
   logic             rise, inc;

   // Divisor 0 matches when the stage wraps to 0, i.e. a period of 2^DIV_W.
   always_comb begin
      rise      = enable & ~enable_q;
      stage_inc = stage_q + DIV_W'(1);
      stage_d   = stage_q;
      inc       = 1'b0;
      if (rise) begin
         stage_d = '0;
      end else if (enable && tick) begin
         if (stage_inc == div) begin
            stage_d = '0;
            inc     = 1'b1;
         end else begin
            stage_d = stage_inc;
         end
      end

      if (rise)      count_d = '0;
      else if (clr)  count_d = inc ? CNT_W'(1) : '0;
      else if (inc)  count_d = count_q + CNT_W'(1);
      else           count_d = count_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         enable_q <= 1'b0;
         stage_q  <= '0;
         count_q  <= '0;
      end else if (cen) begin
         enable_q <= enable;
         stage_q  <= stage_d;
         count_q  <= count_d;
      end
   end

   assign count = count_q;

`ifdef APU_TIMER_OVF_EN
   logic ovf_q, ovf_d;

   always_comb begin
      ovf_d = ovf_q;
      if (rise || clr)      ovf_d = 1'b0;
      if (inc && &count_q)  ovf_d = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)    ovf_q <= 1'b0;
      else if (cen) ovf_q <= ovf_d;
   end

   assign ovf = ovf_q;
`endif

endmodule

// File: rtl/apu_timer_bank.sv
// SPC700-style timer bank: shared slow/fast prescalers, divisor registers, count read mux.
// Define APU_TIMER_OVF_EN to add the per-channel sticky ovf output.
module apu_timer_bank
   import apu_pkg::*;
#(
   parameter int unsigned       CH_NUM    = APU_TIMER_CH_NUM,
   parameter int unsigned       DIV_W     = 8,
   parameter int unsigned       CNT_W     = 4,
   parameter int unsigned       PRE_SLOW  = APU_TIMER_PRE_SLOW,
   parameter int unsigned       PRE_FAST  = APU_TIMER_PRE_FAST,
   parameter logic [CH_NUM-1:0] FAST_MASK = CH_NUM'(3'b100)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cen,
   input  logic [CH_NUM-1:0]  enable,
   apu_timer_bank_if.slave    bus
`ifdef APU_TIMER_OVF_EN
   ,
   output logic [CH_NUM-1:0]  ovf
`endif
);

   localparam int unsigned CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
   localparam int unsigned SW   = (PRE_SLOW > 1) ? $clog2(PRE_SLOW) : 1;
   localparam int unsigned FW   = (PRE_FAST > 1) ? $clog2(PRE_FAST) : 1;

   logic [SW-1:0] slow_q;
   logic [FW-1:0] fast_q;
   logic          slow_tick, fast_tick;

   // Terminal count is the PRE_x-th cen cycle after reset.
   assign slow_tick = cen && (slow_q == SW'(PRE_SLOW - 1));
   assign fast_tick = cen && (fast_q == FW'(PRE_FAST - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slow_q <= '0;
         fast_q <= '0;
      end else if (cen) begin
         slow_q <= slow_tick ? '0 : slow_q + SW'(1);
         fast_q <= fast_tick ? '0 : fast_q + FW'(1);
      end
   end

   logic [CH_NUM-1:0][DIV_W-1:0] div_r;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_r <= '0;
      end else if (cen && bus.div_we) begin
         for (int i = 0; i < int'(CH_NUM); i++) begin
            if (bus.wr_ch == CH_W'(i)) div_r[i] <= bus.div_wdata;
         end
      end
   end

   assign bus.div_q = div_r;

   logic [CNT_W-1:0] count [CH_NUM];

   for (genvar i = 0; i < int'(CH_NUM); i++) begin : g_ch
      apu_timer_ch #(
         .DIV_W (DIV_W),
         .CNT_W (CNT_W)
      ) u_ch (
         .clk    (clk),
         .reset  (reset),
         .cen    (cen),
         .enable (enable[i]),
         .tick   (FAST_MASK[i] ? fast_tick : slow_tick),
         .clr    (bus.cnt_re && (bus.rd_ch == CH_W'(i))),
         .div    (div_r[i]),
         .count  (count[i])
`ifdef APU_TIMER_OVF_EN
         ,
         .ovf    (ovf[i])
`endif
      );
   end

   always_comb begin
      bus.cnt_rdata = '0;
      for (int i = 0; i < int'(CH_NUM); i++) begin
         if (bus.rd_ch == CH_W'(i)) bus.cnt_rdata = count[i];
      end
   end

endmodule

// File: tb/tb_apu_timer_bank.sv
// Directed bench for apu_timer_bank; cycle counts are cen cycles since reset release.
module tb_apu_timer_bank;
   import apu_pkg::*;

   logic       clk    = 1'b0;
   logic       reset  = 1'b1;
   logic       cen    = 1'b1;
   logic [2:0] enable = 3'b000;
`ifdef APU_TIMER_OVF_EN
   logic [2:0] ovf;
`endif
   int n_checks = 0;
   int n_fail   = 0;

   apu_timer_bank_if #(.CH_NUM(3), .DIV_W(8), .CNT_W(4)) bus ();

   apu_timer_bank dut (
      .clk    (clk),
      .reset  (reset),
      .cen    (cen),
      .enable (enable),
      .bus    (bus)
`ifdef APU_TIMER_OVF_EN
      ,
      .ovf    (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      enable = 3'b000;
      bus.div_we = 1'b0;
      bus.cnt_re = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic write_div(input logic [1:0] ch, input logic [7:0] val);
      bus.div_we = 1'b1;
      bus.wr_ch = ch;
      bus.div_wdata = val;
      cyc(1);
      bus.div_we = 1'b0;
   endtask

   task automatic test_reset();
      cyc(2);
      for (int i = 0; i < 3; i++) begin
         bus.rd_ch = 2'(i);
         #1;
         n_checks++;
         if (bus.cnt_rdata !== 4'd0) begin
            $display("FAIL reset_cnt ch%0d got %0d want 0", i, bus.cnt_rdata); n_fail++;
         end
      end
      n_checks++;
      if (bus.div_q !== 24'h0) begin
         $display("FAIL reset_div_q got %h want 000000", bus.div_q); n_fail++;
      end
`ifdef APU_TIMER_OVF_EN
      n_checks++;
      if (ovf !== 3'b000) begin $display("FAIL reset_ovf got %b want 000", ovf); n_fail++; end
`endif
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_div2();
      do_reset();
      write_div(apu_timer_ch_of(AT_TIMER0), 8'd2);
      enable = 3'b001;
      bus.rd_ch = apu_timer_ch_of(AT_COUNTER0);
      cyc(1);
      n_checks++;
      if (bus.div_q !== 24'h000002) begin
         $display("FAIL div2_div_q got %h want 000002", bus.div_q); n_fail++;
      end
      cyc(253);
      n_checks++;
      if (bus.cnt_rdata !== 4'd0) begin
         $display("FAIL div2_255 got %0d want 0", bus.cnt_rdata); n_fail++;
      end
      cyc(1);
      n_checks++;
      if (bus.cnt_rdata !== 4'd1) begin
         $display("FAIL div2_256 got %0d want 1", bus.cnt_rdata); n_fail++;
      end
      cyc(256);
      n_checks++;
      if (bus.cnt_rdata !== 4'd2) begin
         $display("FAIL div2_512 got %0d want 2", bus.cnt_rdata); n_fail++;
      end
   endtask

   task automatic test_fast();
      do_reset();
      write_div(2'd2, 8'd0);
      bus.div_we = 1'b1;
      bus.wr_ch = 2'd3;
      bus.div_wdata = 8'hAA;
      enable = 3'b100;
      bus.rd_ch = 2'd2;
      cyc(1);
      bus.div_we = 1'b0;
      n_checks++;
      if (bus.div_q !== 24'h0) begin
         $display("FAIL fast_oob_write got %h want 000000", bus.div_q); n_fail++;
      end
      cyc(4093);
      n_checks++;
      if (bus.cnt_rdata !== 4'd0) begin
         $display("FAIL fast_4095 got %0d want 0", bus.cnt_rdata); n_fail++;
      end
      cyc(1);
      n_checks++;
      if (bus.cnt_rdata !== 4'd1) begin
         $display("FAIL fast_4096 got %0d want 1", bus.cnt_rdata); n_fail++;
      end
      bus.rd_ch = 2'd3;
      #1;
      n_checks++;
      if (bus.cnt_rdata !== 4'd0) begin
         $display("FAIL oob_read got %0d want 0", bus.cnt_rdata); n_fail++;
      end
   endtask

   task automatic test_read();
      do_reset();
      write_div(2'd1, 8'd1);
      enable = 3'b010;
      bus.rd_ch = 2'd1;
      cyc(639);
      n_checks++;
      if (bus.cnt_rdata !== 4'd5) begin
         $display("FAIL read_640 got %0d want 5", bus.cnt_rdata); n_fail++;
      end
      bus.cnt_re = 1'b1;
      cyc(1);
      bus.cnt_re = 1'b0;
      n_checks++;
      if (bus.cnt_rdata !== 4'd0) begin
         $display("FAIL read_clear got %0d want 0", bus.cnt_rdata); n_fail++;
      end
      cyc(127);
      n_checks++;
      if (bus.cnt_rdata !== 4'd1) begin
         $display("FAIL read_768 got %0d want 1", bus.cnt_rdata); n_fail++;
      end
      cyc(127);
      bus.cnt_re = 1'b1;
      n_checks++;
      if (bus.cnt_rdata !== 4'd1) begin
         $display("FAIL read_coinc_old got %0d want 1", bus.cnt_rdata); n_fail++;
      end
      cyc(1);
      bus.cnt_re = 1'b0;
      n_checks++;
      if (bus.cnt_rdata !== 4'd1) begin
         $display("FAIL read_coinc_after got %0d want 1", bus.cnt_rdata); n_fail++;
      end
      cyc(128);
      n_checks++;
      if (bus.cnt_rdata !== 4'd2) begin
         $display("FAIL read_1024 got %0d want 2", bus.cnt_rdata); n_fail++;
      end
   endtask

   task automatic test_enable_drop();
      do_reset();
      write_div(2'd0, 8'd4);
      enable = 3'b001;
      bus.rd_ch = 2'd0;
      cyc(1791);
      n_checks++;
      if (bus.cnt_rdata !== 4'd3) begin
         $display("FAIL en_1792 got %0d want 3", bus.cnt_rdata); n_fail++;
      end
      enable = 3'b000;
      cyc(1000);
      n_checks++;
      if (bus.cnt_rdata !== 4'd3) begin
         $display("FAIL en_hold got %0d want 3", bus.cnt_rdata); n_fail++;
      end
      enable = 3'b001;
      cyc(1);
      n_checks++;
      if (bus.cnt_rdata !== 4'd0) begin
         $display("FAIL en_rise_clear got %0d want 0", bus.cnt_rdata); n_fail++;
      end
      cyc(406);
      n_checks++;
      if (bus.cnt_rdata !== 4'd0) begin
         $display("FAIL en_3199 got %0d want 0", bus.cnt_rdata); n_fail++;
      end
      cyc(1);
      n_checks++;
      if (bus.cnt_rdata !== 4'd1) begin
         $display("FAIL en_3200 got %0d want 1", bus.cnt_rdata); n_fail++;
      end
   endtask

   task automatic test_wrap();
      do_reset();
      write_div(2'd0, 8'd1);
      enable = 3'b001;
      bus.rd_ch = 2'd0;
      cyc(1919);
      n_checks++;
      if (bus.cnt_rdata !== 4'd15) begin
         $display("FAIL wrap_1920 got %0d want 15", bus.cnt_rdata); n_fail++;
      end
`ifdef APU_TIMER_OVF_EN
      n_checks++;
      if (ovf !== 3'b000) begin $display("FAIL ovf_pre got %b want 000", ovf); n_fail++; end
`endif
      cyc(128);
      n_checks++;
      if (bus.cnt_rdata !== 4'd0) begin
         $display("FAIL wrap_2048 got %0d want 0", bus.cnt_rdata); n_fail++;
      end
`ifdef APU_TIMER_OVF_EN
      n_checks++;
      if (ovf !== 3'b001) begin $display("FAIL ovf_set got %b want 001", ovf); n_fail++; end
`endif
      bus.cnt_re = 1'b1;
      cyc(1);
      bus.cnt_re = 1'b0;
`ifdef APU_TIMER_OVF_EN
      n_checks++;
      if (ovf !== 3'b000) begin $display("FAIL ovf_clear got %b want 000", ovf); n_fail++; end
`endif
   endtask

   task automatic test_reset_mid();
      do_reset();
      write_div(2'd0, 8'd1);
      enable = 3'b001;
      bus.rd_ch = 2'd0;
      cyc(299);
      n_checks++;
      if (bus.cnt_rdata !== 4'd2) begin
         $display("FAIL rmid_300 got %0d want 2", bus.cnt_rdata); n_fail++;
      end
      reset = 1'b1;
      #1;
      n_checks++;
      if (bus.cnt_rdata !== 4'd0 || bus.div_q !== 24'h0) begin
         $display("FAIL rmid_async got cnt=%0d div_q=%h want 0/000000",
                  bus.cnt_rdata, bus.div_q);
         n_fail++;
      end
      @(negedge clk);
      reset = 1'b0;
      write_div(2'd0, 8'd1);
      cyc(126);
      n_checks++;
      if (bus.cnt_rdata !== 4'd0) begin
         $display("FAIL rmid_127 got %0d want 0", bus.cnt_rdata); n_fail++;
      end
      cyc(1);
      n_checks++;
      if (bus.cnt_rdata !== 4'd1) begin
         $display("FAIL rmid_128 got %0d want 1", bus.cnt_rdata); n_fail++;
      end
   endtask

   initial begin
      bus.div_we = 1'b0;
      bus.wr_ch = 2'd0;
      bus.div_wdata = 8'd0;
      bus.cnt_re = 1'b0;
      bus.rd_ch = 2'd0;
      test_reset();
      test_div2();
      test_fast();
      test_read();
      test_enable_drop();
      test_wrap();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/apu_timer_bank.md
Name: apu_timer_bank

Overview:
- Parametrised SPC700-style timer bank. Generalises the fixed three-timer TIMERx/COUNTERx register set to CH_NUM channels, with configurable divisor width, counter width and per-channel prescaler selection.
- Sits in the APU between the address decoder (AT_TIMERx writes, AT_COUNTERx reads, AT_CONTROL enable bits) and the SPC700 data bus.
- Each channel divides a shared prescaled tick by a programmable divisor and accumulates a clear-on-read up-counter.

Parameters:
- CH_NUM, 3: number of timer channels (1..8).
- DIV_W, 8: divisor and stage-counter width. A divisor of 0 means 2^DIV_W.
- CNT_W, 4: output counter width.
- PRE_SLOW, 128: cen cycles per slow tick (8 kHz at 1.024 MHz).
- PRE_FAST, 16: cen cycles per fast tick (64 kHz).
- FAST_MASK, 3'b100: bit i = 1 means channel i uses the fast tick. Width is CH_NUM.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cen  in  1  SPC700 cycle enable; all state advances only when cen=1
- enable  in  CH_NUM  per-channel run enable (CONTROL register bits)
- div_we  in  1  divisor write strobe, qualified by cen
- wr_ch  in  $clog2(CH_NUM)  channel addressed by the write
- div_wdata  in  DIV_W  divisor value
- cnt_re  in  1  counter read strobe, qualified by cen
- rd_ch  in  $clog2(CH_NUM)  channel addressed by the read
- cnt_rdata  out  CNT_W  counter value of rd_ch (combinational)
- div_q  out  CH_NUM*DIV_W  packed divisor registers, for debug/readback

Behaviour:
- Reset: all divisors, stage counters, output counters and prescalers are 0. div_q=0; cnt_rdata=0. Reset takes effect immediately, including mid-count.
- Prescalers:
  - Two free-running counters, independent of enable.
  - slow_tick pulses for one cen cycle every PRE_SLOW cen cycles; fast_tick likewise every PRE_FAST.
  - First tick after reset occurs on the PRE_x-th cen cycle.
- Channel tick: tick_i = FAST_MASK[i] ? fast_tick : slow_tick.
- Enable edge:
  - enable[i] is sampled on cen cycles.
  - A 0->1 transition clears stage_i and count_i in that cycle; any tick in that cycle is ignored.
  - While enable[i]=0, stage_i and count_i hold.
- Counting, when enable[i]=1 and tick_i:
  - stage_i increments.
  - If the incremented value equals div_i (div_i=0 compares against 2^DIV_W, i.e. wrap to 0), stage_i becomes 0 and count_i increments modulo 2^CNT_W.
- Divisor write:
  - div_we writes div[wr_ch] and takes effect the next cycle.
  - stage is not cleared. If the new divisor is at or below the current stage, the stage continues up to wrap-around before matching (hardware-faithful).
  - A write to wr_ch >= CH_NUM is ignored.
- Read:
  - cnt_rdata = count[rd_ch] combinationally, or 0 when rd_ch >= CH_NUM.
  - cnt_re clears count[rd_ch] at the clock edge.
- Simultaneous read and increment on the same channel: cnt_rdata returns the pre-increment value, and count becomes 1. The increment is not lost.
- Simultaneous divisor write and tick on the same channel: the compare uses the old divisor.
- Latency: count update is visible on cnt_rdata one clk after the tick cycle.

Optional Feature:
- Macro APU_TIMER_OVF_EN.
- When defined:
  - Adds output port ovf, CH_NUM bits.
  - ovf[i] is a sticky flag, set when count_i wraps from all-ones to 0.
  - Cleared by cnt_re on channel i, and by the 0->1 enable edge.
  - Set wins over clear when both occur in the same cycle.
  - Reset value 0.
- When undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Add to apu_pkg:
  - APU_TIMER_CH_NUM = 3, APU_TIMER_PRE_SLOW = 128, APU_TIMER_PRE_FAST = 16.
  - Packed struct apu_timer_state_t {stage, count} for the default widths.
  - Helper function mapping AT_TIMER0..2 / AT_COUNTER0..2 to a channel index.
- One sub-module, apu_timer_ch: enable-edge detect, stage counter, divisor compare, count register, optional ovf. Instantiated CH_NUM times via generate.
- Prescalers and read/write muxing stay in apu_timer_bank.

Test Plan:
- Write div[0]=2, raise enable[0], keep cen=1 -> count[0]=1 after 256 cen cycles, and 2 after 512.
- Write div[2]=0, enable[2] (fast channel) -> first count after 256*16 = 4096 cen cycles.
- Let count[1] reach 5, then pulse cnt_re with rd_ch=1 -> cnt_rdata=5 in that cycle, 0 the next cycle. Read coincident with the increment cycle -> cnt_rdata is the old value, count=1 afterwards.
- Drop enable[0] at count 3 with stage mid-way, hold for 1000 cycles, re-raise -> count and stage cleared, and the next increment takes a full divisor period.
- div[0]=1, run 16 slow ticks -> count wraps 15->0; with APU_TIMER_OVF_EN, ovf[0]=1 until read.
- Assert reset mid-count, deasserted synchronously later -> all outputs 0 immediately; prescaler restarts, so the first tick occurs PRE_SLOW cen cycles after release.
